coeff_capture: RTL

- Receiving end of the twiddle-coefficient stream: deserializes one W=2*NBITS-bit coefficient per valid cycle into a parallel bank of N coefficients.
- Bank layout matches the coefficient ROM flat-bus convention: coefficient 0 in the MSB slot.
- Double-buffered: the published bank stays stable while the next frame fills.
- Feeds FFT butterfly stages that need all N twiddles in parallel.

---
 rtl/coeff_capture_if.sv | 25 ++
 rtl/coeff_capture.sv | 93 +++++++++
 2 files changed

// File: rtl/coeff_capture_if.sv
// rtl/coeff_capture_if.sv - coefficient stream in, parallel twiddle bank out
interface coeff_capture_if #(
  parameter int NBITS = 2,
  parameter int N     = 8
);
  localparam int W = 2 * NBITS;

  logic [W-1:0]   coeff_in;
  logic           coeff_valid_in;
  logic           coeff_sof;
  logic [N*W-1:0] coeff_bank;
  logic           bank_valid;
  logic           coeff_done;
  logic           frame_err;

  modport master (
    output coeff_in, coeff_valid_in, coeff_sof,
    input  coeff_bank, bank_valid, coeff_done, frame_err
  );

  modport slave (
    input  coeff_in, coeff_valid_in, coeff_sof,
    output coeff_bank, bank_valid, coeff_done, frame_err
  );
endinterface

// File: rtl/coeff_capture.sv
// rtl/coeff_capture.sv - double-buffered deserializer of N twiddle words into one bank
module coeff_capture #(
  parameter int NBITS = 2,
  parameter int N     = 8
) (
  input  logic            clk,
  input  logic            rst,
  coeff_capture_if.slave  cif
);
  localparam int W  = 2 * NBITS;
  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {IDLE, FILL} state_t;

  state_t         state, state_next;
  logic [CW-1:0]  cnt, cnt_next;
  logic [N*W-1:0] shadow, shadow_next;
  logic           commit, abort;

  // Slot 0 lives in the MSBs, matching the coefficient ROM flat bus.
  function automatic logic [N*W-1:0] put_slot(input logic [N*W-1:0] b,
                                              input int k,
                                              input logic [W-1:0] w);
    logic [N*W-1:0] r;
    r = b;
    r[(N-1-k)*W +: W] = w;
    return r;
  endfunction

  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    shadow_next = shadow;
    commit      = 1'b0;
    abort       = 1'b0;
    case (state)
      IDLE: begin
        if (cif.coeff_valid_in && cif.coeff_sof) begin
          shadow_next = put_slot(shadow, 0, cif.coeff_in);
          if (N == 1) begin
            commit = 1'b1;
          end else begin
            cnt_next   = CW'(1);
            state_next = FILL;
          end
        end
      end
      FILL: begin
        if (cif.coeff_valid_in) begin
          if (cif.coeff_sof) begin
            // Early restart: the partial frame is discarded, the new word opens a fresh one.
            abort       = 1'b1;
            shadow_next = put_slot(shadow, 0, cif.coeff_in);
            cnt_next    = CW'(1);
          end else begin
            shadow_next = put_slot(shadow, int'(cnt), cif.coeff_in);
            if (cnt == LAST) begin
              commit     = 1'b1;
              cnt_next   = '0;
              state_next = IDLE;
            end else begin
              cnt_next = cnt + CW'(1);
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      cnt            <= '0;
      shadow         <= '0;
      cif.coeff_bank <= '0;
      cif.bank_valid <= 1'b0;
      cif.coeff_done <= 1'b0;
      cif.frame_err  <= 1'b0;
    end else begin
      state          <= state_next;
      cnt            <= cnt_next;
      shadow         <= shadow_next;
      cif.coeff_done <= commit;
      cif.frame_err  <= abort;
      if (commit) begin
        cif.coeff_bank <= shadow_next;
        cif.bank_valid <= 1'b1;
      end
    end
  end
endmodule
